md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Sequential multiply/divide unit with HI/LO registers, one stage downstream of the GRF read ports in the execute stage.
- Consumes the rs/rt register values and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO for MFHI/MFLO, plus a busy/stall indication for the pipeline hazard unit.
- Models the fixed multi-cycle latency of the course MIPS multiply/divide hardware.

Parameters:
MULT_CYCLES, 5, busy duration for MULT/MULTU; legal range 1..15
DIV_CYCLES, 10, busy duration for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe for the operation on md_op; sampled on the rising edge
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
src_a  input  32  rs value (dividend / multiplicand / MTHI-MTLO data)
src_b  input  32  rt value (divisor / multiplier)
busy  output  1  registered; high while a mult/div is in flight
stall_req  output  1  combinational: busy | (start & md_op in {0..3})
hi  output  32  registered HI
lo  output  32  registered LO

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, internal counter=0, pending result=0. Reset overrides everything.
  - An in-flight operation is aborted and its result discarded.
  - A start in the same cycle as reset is ignored.
- Issue:
  - An op is accepted on a rising edge where start=1 and busy=0.
  - start while busy=1 is ignored entirely, including MTHI/MTLO. The hazard unit holds it via stall_req.
- MTHI/MTLO:
  - On acceptance, hi<=src_a (MTHI) or lo<=src_a (MTLO) on that same edge.
  - busy stays 0.
- MULT/MULTU/DIV/DIVU acceptance edge:
  - Compute the result from src_a/src_b and latch it into internal pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES and set busy<=1.
  - hi/lo are unchanged on this edge.
- Countdown:
  - Each following edge with busy=1 decrements counter.
  - On the edge where counter==1: hi/lo <= pending, counter<=0, busy<=0.
  - busy is therefore high for exactly N cycles, and the new hi/lo appear on the same edge busy falls.
  - A new op may be accepted on the edge after busy falls, not on the falling edge itself.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: the same, unsigned.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Division by zero: the unit still goes busy for DIV_CYCLES; hi/lo are left unchanged at completion.
- Operands are captured at acceptance. Later changes on src_a/src_b during busy have no effect.
- md_op values 6-7 with start=1: no state change.
- stall_req is purely combinational:
  - It covers the in-flight case (busy).
  - It also covers the issue cycle of a mult/div, so a dependent MFHI/MFLO in the next stage stalls.
- hi/lo are readable at any time; while busy=1 they hold the pre-operation values.

Test Plan:
- Reset, then idle -> hi=0, lo=0, busy=0, stall_req=0.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 with start=1 for one cycle -> stall_req=1 in the issue cycle; busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU of the same operands -> after 5 busy cycles hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for exactly 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV by 0 with prior hi=0x11, lo=0x22 -> busy for 10 cycles; then hi=0x11, lo=0x22.
- Start a MULT, then pulse MTHI 0xAAAA at busy cycle 2 and drive new src values -> MTHI ignored, final hi/lo from the original MULT.
- MTLO 0x1234 the cycle after busy falls -> lo=0x1234 next edge, busy stays 0.
- Assert reset at busy cycle 3 of a DIV -> next edge: busy=0, hi=0, lo=0; no later write-back occurs.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers and pipeline stall request
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_phi, r_plo;
  logic        w_na, w_nb;
  logic [31:0] w_ma, w_mb, w_q, w_r, w_dq, w_dr;
  logic [63:0] w_smul, w_umul, w_res;
  always_comb begin
    w_smul = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    w_umul = {32'b0, src_a} * {32'b0, src_b};
    w_na   = src_a[31] & ~md_op[0];
    w_nb   = src_b[31] & ~md_op[0];
    w_ma   = w_na ? -src_a : src_a;
    w_mb   = w_nb ? -src_b : src_b;
    w_q    = w_ma / w_mb;
    w_r    = w_ma % w_mb;
    w_dq   = (w_na ^ w_nb) ? -w_q : w_q;
    w_dr   = w_na ? -w_r : w_r;
    // a zero divisor re-latches the current HI/LO so completion leaves them untouched
    w_res  = md_op[1] ? ((src_b == 32'd0) ? {r_hi, r_lo} : {w_dr, w_dq})
                      : (md_op[0] ? w_umul : w_smul);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_phi  <= 32'd0;
      r_plo  <= 32'd0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        r_hi   <= r_phi;
        r_lo   <= r_plo;
      end
    end else if (start) begin
      if (md_op == 3'd4) r_hi <= src_a;
      if (md_op == 3'd5) r_lo <= src_a;
      if (!md_op[2]) begin
        {r_phi, r_plo} <= w_res;
        r_cnt          <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        r_busy         <= 1'b1;
      end
    end
  end
  assign busy      = r_busy;
  assign stall_req = r_busy | (start & ~md_op[2]);
  assign hi        = r_hi;
  assign lo        = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed check of md_unit against an arithmetic reference model
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_dz;
  int          m_left;
  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_edge(input bit r, input bit s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (r) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (s) begin
      if (op == 4) m_hi = a;
      else if (op == 5) m_lo = a;
      else if (op < 4) begin
        m_left = (op < 2) ? 5 : 10;
        m_dz   = (op >= 2) && (b == 0);
        case (op)
          3'd0: {m_phi, m_plo} = 64'(sa * sb);
          3'd1: begin up = {32'b0, a} * {32'b0, b}; {m_phi, m_plo} = up; end
          3'd2: if (!m_dz) begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
          default: if (!m_dz) begin m_plo = a / b; m_phi = a % b; end
        endcase
      end
    end
  endtask
  task automatic cyc(input bit r, input bit s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    reset = r; start = s; md_op = op; src_a = a; src_b = b;
    #1 chk("stall_req", stall_req, (m_left > 0) || (s && op < 4));
    @(posedge clk);
    model_edge(r, s, op, a, b);
    @(negedge clk);
    chk("busy", busy, m_left > 0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 3'($urandom), $urandom, $urandom);
  endtask
  initial begin
    reset = 1; start = 0; md_op = 0; src_a = 0; src_b = 0;
    repeat (2) @(negedge clk);
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_dz = 0;
    cyc(1, 1, 3'd4, 32'h5555, 0);
    idle(2);
    chk("reset_hi", hi, 0);
    cyc(0, 1, 3'd0, 32'hFFFFFFFE, 3);
    idle(4);
    chk("mult_busy_last", busy, 1);
    idle(1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    cyc(0, 1, 3'd1, 32'hFFFFFFFE, 3);
    idle(5);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    cyc(0, 1, 3'd2, 32'hFFFFFFF9, 2);
    idle(9);
    chk("div_busy_last", busy, 1);
    idle(1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    cyc(0, 1, 3'd3, 7, 2);
    idle(10);
    chk("divu_lo", lo, 3);
    chk("divu_hi", hi, 1);
    cyc(0, 1, 3'd2, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 0);
    cyc(0, 1, 3'd4, 32'h11, 0);
    cyc(0, 1, 3'd5, 32'h22, 0);
    cyc(0, 1, 3'd2, 32'h99, 0);
    idle(10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    cyc(0, 1, 3'd0, 32'h7, 32'h9);
    idle(1);
    cyc(0, 1, 3'd4, 32'hAAAA, 32'h3);
    idle(3);
    chk("mthi_ignored_hi", hi, 0);
    chk("mthi_ignored_lo", lo, 32'd63);
    cyc(0, 1, 3'd5, 32'h1234, 0);
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_busy", busy, 0);
    cyc(0, 1, 3'd6, 32'hDEAD, 1);
    cyc(0, 1, 3'd3, 100, 7);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_lo", lo, 0);
    idle(12);
    chk("rst_no_wb_lo", lo, 0);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, b;
      int k;
      a = $urandom;
      k = $urandom_range(0, 9);
      b = (k == 0) ? 32'd0 : (k < 3) ? 32'($urandom_range(1, 9)) : (k == 3) ? 32'hFFFFFFFF : $urandom;
      if (k == 3 && $urandom_range(0, 1) == 1) a = 32'h80000000;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 3'($urandom), a, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
